bcd_fib_inv: RTL and testbench

//  Inverse Fibonacci with BCD I/O: companion to the BCD Fibonacci generator.

---
 rtl/bcd_fib_inv_pkg.sv | 48 ++++
 rtl/bcd_fib_inv_if.sv | 29 ++
 rtl/bcd_fib_inv_bcd2bin_seq.sv | 34 +++
 rtl/bcd_fib_inv.sv | 141 ++++++++++++++
 tb/tb_bcd_fib_inv.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/bcd_fib_inv_pkg.sv
// Shared types, widths and step helpers for the BCD inverse-Fibonacci block.
// Conversion steps are pure functions so the FSM stays readable.
package bcd_fib_inv_pkg;

  localparam int BIN_W = 14;
  localparam int FIB_W = 15;
  localparam int IDX_W = 5;
  localparam int DD_W  = 8 + IDX_W;

  localparam logic [3:0] C3 = 4'd3;
  localparam logic [3:0] C4 = 4'd4;
  localparam logic [3:0] C8 = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BCD2BIN,
    S_SEARCH,
    S_BIN2BCD,
    S_DONE
  } state_t;

  // {bcd[15:0], bin[15:0]} >> 1, then pull BCD nibbles >= 8 down by 3
  function automatic logic [31:0] b2b_step(
    input logic [31:0] x
  );
    logic [31:0] y;
    y = x >> 1;
    for (int i = 0; i < 4; i++) begin
      if (y[16+4*i +: 4] >= C8)
        y[16+4*i +: 4] = y[16+4*i +: 4] - C3;
    end
    return y;
  endfunction

  // {tens, units, idx}: add 3 to digits > 4, then shift left
  function automatic logic [DD_W-1:0] dd_step(
    input logic [DD_W-1:0] x
  );
    logic [DD_W-1:0] y;
    y = x;
    for (int i = 0; i < 2; i++) begin
      if (y[IDX_W+4*i +: 4] > C4)
        y[IDX_W+4*i +: 4] = y[IDX_W+4*i +: 4] + C3;
    end
    return y << 1;
  endfunction

endpackage

// File: rtl/bcd_fib_inv_if.sv
// Front-panel request/result bundle for the inverse-Fibonacci block.
// master drives the request, slave is the block itself.
interface bcd_fib_inv_if;

  logic       start;
  logic [3:0] bcd3;
  logic [3:0] bcd2;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic       ready;
  logic       done_tick;
  logic [3:0] idx_bcd1;
  logic [3:0] idx_bcd0;
  logic       exact;
  logic       err;

  modport master (
    output start, bcd3, bcd2, bcd1, bcd0,
    input  ready, done_tick, idx_bcd1,
    input  idx_bcd0, exact, err
  );

  modport slave (
    input  start, bcd3, bcd2, bcd1, bcd0,
    output ready, done_tick, idx_bcd1,
    output idx_bcd0, exact, err
  );

endinterface

// File: rtl/bcd_fib_inv_bcd2bin_seq.sv
// 16-cycle serial BCD to binary converter (shift right, subtract 3).
// o_done is high during the cycle whose edge makes the last shift.
module bcd2bin_seq
  import bcd_fib_inv_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic [15:0]      i_bcd,
  output logic             o_done,
  output logic [BIN_W-1:0] o_bin
);

  logic [31:0] r_sh;
  logic [4:0]  r_cnt;

  // load on start, then one shift/correct step per cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_sh  <= {i_bcd, 16'd0};
      r_cnt <= 5'd16;
    end else if (r_cnt != 5'd0) begin
      r_sh  <= b2b_step(r_sh);
      r_cnt <= r_cnt - 5'd1;
    end
  end

  assign o_done = (r_cnt == 5'd1);
  assign o_bin  = r_sh[BIN_W-1:0];

endmodule

// File: rtl/bcd_fib_inv.sv
// Inverse Fibonacci with BCD I/O: largest n with fib(n) <= V.
// BCD->bin, step Fibonacci pairs until past V, idx back to BCD.
module bcd_fib_inv
  import bcd_fib_inv_pkg::*;
(
  input logic           clk,
  input logic           reset_n,
  bcd_fib_inv_if.slave  bus
);

  state_t            r_state;
  state_t            w_next;
  logic              w_cvt_go;
  logic              w_cvt_done;
  logic              w_bad;
  logic              w_over;
  logic [15:0]       w_bcd;
  logic [BIN_W-1:0]  w_bin;
  logic [DD_W-1:0]   w_dd_nx;

  logic [FIB_W-1:0]  r_fcur;
  logic [FIB_W-1:0]  r_fnxt;
  logic [IDX_W-1:0]  r_k;
  logic [DD_W-1:0]   r_dd;
  logic [2:0]        r_cnt;
  logic              r_ready;
  logic              r_done;
  logic [3:0]        r_idx1;
  logic [3:0]        r_idx0;
  logic              r_exact;
  logic              r_err;

  assign w_bcd   = {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
  assign w_bad   = (bus.bcd3 > 4'd9) || (bus.bcd2 > 4'd9) ||
                   (bus.bcd1 > 4'd9) || (bus.bcd0 > 4'd9);
  assign w_over  = (r_fnxt > {1'b0, w_bin});
  assign w_dd_nx = dd_step(r_dd);

  bcd2bin_seq u_cvt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (w_cvt_go),
    .i_bcd   (w_bcd),
    .o_done  (w_cvt_done),
    .o_bin   (w_bin)
  );

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // next state and converter kick-off
  always_comb begin
    w_next   = r_state;
    w_cvt_go = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_bad) begin
            w_next = S_DONE;
          end else begin
            w_next   = S_BCD2BIN;
            w_cvt_go = 1'b1;
          end
        end
      end
      S_BCD2BIN: if (w_cvt_done) w_next = S_SEARCH;
      S_SEARCH:  if (w_over) w_next = S_BIN2BCD;
      S_BIN2BCD: if (r_cnt == 3'd1) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fcur  <= '0;
      r_fnxt  <= '0;
      r_k     <= '0;
      r_dd    <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_idx1  <= '0;
      r_idx0  <= '0;
      r_exact <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= (w_next == S_IDLE);
      r_done  <= (w_next == S_DONE);
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_idx1  <= '0;
            r_idx0  <= '0;
            r_exact <= 1'b0;
            r_err   <= w_bad;
          end
        end
        S_BCD2BIN: begin
          if (w_cvt_done) begin
            r_fcur <= '0;
            r_fnxt <= {{(FIB_W-1){1'b0}}, 1'b1};
            r_k    <= '0;
          end
        end
        S_SEARCH: begin
          if (w_over) begin
            r_exact <= (r_fcur == {1'b0, w_bin});
            r_dd    <= {8'd0, r_k};
            r_cnt   <= 3'd5;
          end else begin
            r_fcur <= r_fnxt;
            r_fnxt <= r_fcur + r_fnxt;
            r_k    <= r_k + 1'b1;
          end
        end
        S_BIN2BCD: begin
          r_dd  <= w_dd_nx;
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_idx1 <= w_dd_nx[DD_W-1 -: 4];
            r_idx0 <= w_dd_nx[IDX_W +: 4];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready     = r_ready;
  assign bus.done_tick = r_done;
  assign bus.idx_bcd1  = r_idx1;
  assign bus.idx_bcd0  = r_idx0;
  assign bus.exact     = r_exact;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_bcd_fib_inv.sv
// Bench for bcd_fib_inv: directed corners plus random values,
// checked against a Fibonacci-table reference model.
module tb_bcd_fib_inv;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  bcd_fib_inv_if bus ();

  bcd_fib_inv dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // largest n with fib(n) <= v, and whether it is hit exactly
  function automatic void ref_model(
    input  int v,
    output int idx,
    output bit ex
  );
    int fib [22];
    fib[0] = 0;
    fib[1] = 1;
    for (int i = 2; i < 22; i++) fib[i] = fib[i-1] + fib[i-2];
    idx = 0;
    ex  = 1'b0;
    for (int i = 0; i < 22; i++) begin
      if (fib[i] <= v) begin
        idx = i;
        ex  = (fib[i] == v);
      end
    end
  endfunction

  task automatic run_v(
    input logic [3:0] d3, d2, d1, d0,
    input int         mid,
    input string      tag
  );
    int e_idx, e_lat, lat, rdy_hi, v;
    bit e_ex, e_err;
    e_err = (d3 > 9) || (d2 > 9) || (d1 > 9) || (d0 > 9);
    v = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
    if (e_err) begin
      e_idx = 0;
      e_ex  = 1'b0;
      e_lat = 1;
    end else begin
      ref_model(v, e_idx, e_ex);
      e_lat = e_idx + 23;
    end
    @(negedge clk);
    bus.bcd3  = d3;
    bus.bcd2  = d2;
    bus.bcd1  = d1;
    bus.bcd0  = d0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat    = 0;
    rdy_hi = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.ready) rdy_hi++;
      if (bus.done_tick) begin
        lat = c;
        break;
      end
      if (c == mid) begin
        bus.start = 1'b1;
        bus.bcd3  = 4'd9;
        bus.bcd2  = 4'd9;
        bus.bcd1  = 4'd9;
        bus.bcd0  = 4'd9;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_busy_rdy"}, rdy_hi, 0);
    chk({tag, "_idx"}, {bus.idx_bcd1, bus.idx_bcd0},
        {4'(e_idx / 10), 4'(e_idx % 10)});
    chk({tag, "_exact"}, bus.exact, e_ex);
    chk({tag, "_err"}, bus.err, e_err);
    @(negedge clk);
    chk({tag, "_pulse"}, bus.done_tick, 0);
    chk({tag, "_rdy"}, bus.ready, 1);
  endtask

  initial begin
    logic [3:0] d [4];
    n_vec     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.bcd3  = '0;
    bus.bcd2  = '0;
    bus.bcd1  = '0;
    bus.bcd0  = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.ready, 1);
    chk("rst_done", bus.done_tick, 0);
    chk("rst_idx", {bus.idx_bcd1, bus.idx_bcd0}, 0);
    chk("rst_exact", bus.exact, 0);
    chk("rst_err", bus.err, 0);
    reset_n = 1'b1;

    run_v(0, 0, 0, 0, 0, "v0000");
    run_v(0, 0, 0, 1, 0, "v0001");
    run_v(0, 0, 0, 2, 0, "v0002");
    run_v(0, 1, 0, 0, 8, "v0100");
    run_v(6, 7, 6, 5, 0, "v6765");
    run_v(9, 9, 9, 9, 0, "v9999");
    run_v(1, 2, 4'hA, 4, 0, "bad");

    // abort a search with an asynchronous reset
    @(negedge clk);
    bus.bcd3  = 4'd0;
    bus.bcd2  = 4'd1;
    bus.bcd1  = 4'd0;
    bus.bcd0  = 4'd0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_abort_rdy", bus.ready, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_rdy", bus.ready, 1);
    chk("abort_done", bus.done_tick, 0);
    chk("abort_idx", {bus.idx_bcd1, bus.idx_bcd0}, 0);
    chk("abort_exact", bus.exact, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_v(0, 0, 8, 9, 0, "v0089");

    repeat (25) begin
      for (int i = 0; i < 4; i++) d[i] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0)
        d[$urandom_range(0, 3)] = 4'($urandom_range(10, 15));
      run_v(d[3], d[2], d[1], d[0], int'($urandom_range(0, 30)), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
